plot_arbiter: RTL and testbench
===============================

Name: plot_arbiter

Overview:
- Shares the single VGA adapter plot port among five requesters: player 1-4 trail writers (ids 0-3) and the timer-bar writer (id 4).
- Round-robin arbitration with a req/ack handshake. Each granted pixel is held on x/y/colour with plot asserted for a programmable number of cycles.
- Sits between the game datapath and vga_adapter and replaces the free-running five-state draw sequencer.
- Also gates drawing on the game-running flag and drops off-screen coordinates.

Parameters:
- NREQ, 5: number of requesters (ids 0..NREQ-1). Fixed at 5 for this design; the logic must be written for the generic value.
- PLOT_HOLD, 2: cycles plot stays high per granted pixel. Must be 1..15.
- X_MAX, 160: exclusive x bound. Pixels with x >= X_MAX are dropped.
- Y_MAX, 120: exclusive y bound. Pixels with y >= Y_MAX are dropped.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running. New grants are issued only while this is high.
- req  in  NREQ  per-requester pixel request
- req_x  in  8*NREQ  packed x; requester i uses bits [8i+7:8i]
- req_y  in  7*NREQ  packed y; requester i uses bits [7i+6:7i]
- req_colour  in  3*NREQ  packed colour; requester i uses bits [3i+2:3i]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- x  out  8  pixel x to vga_adapter
- y  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  id of the current or last granted requester
- drop_count  out  8  saturating count of dropped off-screen requests

Behaviour:
- Clock and reset: one clock (CLOCK_50). Reset is synchronous, active-high, and is named reset.
- Reset values: all outputs are 0. State = IDLE, rr_ptr = 0.
- Reset mid-transaction aborts immediately. No ack is issued.

States:
- IDLE -> ARB when enable=1 and req != 0. Otherwise stay in IDLE.
- ARB: select the first i with req[i]=1, searching circularly from rr_ptr.
  - Latch x, y, colour and grant_id=i.
  - If the latched x >= X_MAX or y >= Y_MAX: go to ACK, keep plot=0, and increment drop_count (saturates at 255).
  - Otherwise go to PLOT and load hold counter = PLOT_HOLD.
  - If req dropped to 0 between IDLE and ARB (protocol violation): return to IDLE with no ack.
- PLOT: plot=1. Decrement the hold counter each cycle. Go to ACK after PLOT_HOLD cycles.
- ACK: ack[grant_id]=1 for exactly one cycle, plot=0, rr_ptr = (grant_id+1) mod NREQ. Then go to IDLE.

Outputs and handshake:
- All outputs are registered. x/y/colour hold their value after plot falls, until the next ARB.
- Latency from req high (sampled in IDLE at cycle 0):
  - ARB at cycle 1.
  - plot high for cycles 2..PLOT_HOLD+1.
  - ack at cycle PLOT_HOLD+2.
- A requester holds req and its data stable until it samples ack=1. It must drop req on that same edge, so req is low in the following IDLE cycle.
- At most one ack bit is high in any cycle.
- enable falling mid-transaction: the current transaction completes (plot and ack) and no new grant is issued.
- Simultaneous requests are served in strict circular order starting at rr_ptr. No requester waits more than NREQ-1 grants.
- A requester that re-asserts req immediately after its ack is served only after every other pending requester.

Optional Feature:
- Macro: PLOT_ARB_TIMER_PRIORITY_EN
- Defined: requester NREQ-1 (the timer) wins ARB whenever its req is high, regardless of rr_ptr. rr_ptr is not updated when the timer is granted. Players keep round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters.

Test Plan:
- Reset then idle: req=0, enable=1 for 20 cycles -> plot=0, ack=0, busy=0, all outputs 0.
- Single request: req=5'b00001, x=10, y=20, colour=3'b001, PLOT_HOLD=2 -> plot=1 on cycles 2-3 with x=10/y=20/colour=1, ack=5'b00001 on cycle 4, grant_id=0.
- Fairness: req=5'b11111 held and re-asserted after each ack -> grant order 0,1,2,3,4,0. Each grant is exactly PLOT_HOLD+3 cycles apart. No two ack bits are ever high together.
- Off-screen drop: requester 2 sends x=200, y=5 -> plot stays 0, ack[2] pulses on cycle 2, drop_count 0->1. After 300 such drops, drop_count=255.
- Enable and reset mid-transaction:
  - enable falls during PLOT -> the pixel completes and ack is issued; further pending reqs are ignored until enable=1.
  - reset in PLOT -> next cycle plot=0, ack=0, state IDLE.
- With PLOT_ARB_TIMER_PRIORITY_EN defined: req=5'b10011 with rr_ptr=0 -> timer (id 4) is granted first, then 0, then 1.

Source files
------------

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter sharing the VGA plot port among NREQ pixel requesters
// Optional: PLOT_ARB_TIMER_PRIORITY_EN gives requester NREQ-1 (timer bar) absolute priority.
module plot_arbiter #(
    parameter int NREQ      = 5,
    parameter int PLOT_HOLD = 2,
    parameter int X_MAX     = 160,
    parameter int Y_MAX     = 120
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [7*NREQ-1:0] req_y,
    input  logic [3*NREQ-1:0] req_colour,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic [7:0]        drop_count
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_PLOT, S_ACK} state_t;

    state_t          r_state, w_next_state;
    logic [NREQ-1:0] r_ack, w_ack;
    logic [7:0]      r_x, w_x;
    logic [6:0]      r_y, w_y;
    logic [2:0]      r_colour, w_colour;
    logic            r_plot, w_plot;
    logic            r_busy, w_busy;
    logic [2:0]      r_gid, w_gid;
    logic [7:0]      r_drop, w_drop;
    logic [2:0]      r_rr_ptr, w_rr_ptr;
    logic [3:0]      r_hold, w_hold;

    logic [NREQ-1:0] w_elig, w_sel_oh, w_gid_oh;
    logic [3:0]      w_dist, w_best;
    logic [2:0]      w_sel;
    logic            w_found, w_off;
    logic [7:0]      w_sel_x;
    logic [6:0]      w_sel_y;
    logic [2:0]      w_sel_colour;

    // Winner is the eligible requester with the smallest circular distance from rr_ptr.
    always_comb begin
        w_elig  = req;
        w_sel   = '0;
        w_found = 1'b0;
        w_best  = 4'hF;
        w_dist  = '0;
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
        w_elig[NREQ-1] = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            w_dist = 4'(i) + 4'(NREQ) - {1'b0, r_rr_ptr};
            if (w_dist >= 4'(NREQ)) w_dist = w_dist - 4'(NREQ);
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = 3'(i);
                w_found = 1'b1;
            end
        end
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
        if (req[NREQ-1]) begin
            w_sel   = 3'(NREQ-1);
            w_found = 1'b1;
        end
`endif
    end

    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_oh     = '0;
        w_gid_oh     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_oh[i] = (w_sel == 3'(i));
            w_gid_oh[i] = (r_gid == 3'(i));
            if (w_sel == 3'(i)) begin
                w_sel_x      = req_x[8*i +: 8];
                w_sel_y      = req_y[7*i +: 7];
                w_sel_colour = req_colour[3*i +: 3];
            end
        end
    end

    assign w_off = ({1'b0, w_sel_x} >= 9'(X_MAX)) || ({1'b0, w_sel_y} >= 8'(Y_MAX));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ack    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_gid    <= '0;
            r_drop   <= '0;
            r_rr_ptr <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_next_state;
            r_ack    <= w_ack;
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_colour;
            r_plot   <= w_plot;
            r_busy   <= w_busy;
            r_gid    <= w_gid;
            r_drop   <= w_drop;
            r_rr_ptr <= w_rr_ptr;
            r_hold   <= w_hold;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (enable && (req != '0)) w_next_state = S_ARB;
            S_ARB:   if (!w_found)      w_next_state = S_IDLE;
                     else if (w_off)    w_next_state = S_ACK;
                     else               w_next_state = S_PLOT;
            S_PLOT:  if (r_hold <= 4'd1) w_next_state = S_ACK;
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; ack is raised on entry to ACK so it is high exactly there.
    always_comb begin
        w_ack    = '0;
        w_plot   = 1'b0;
        w_x      = r_x;
        w_y      = r_y;
        w_colour = r_colour;
        w_gid    = r_gid;
        w_drop   = r_drop;
        w_rr_ptr = r_rr_ptr;
        w_hold   = r_hold;
        w_busy   = (w_next_state != S_IDLE);
        case (r_state)
            S_ARB: begin
                if (w_found) begin
                    w_x      = w_sel_x;
                    w_y      = w_sel_y;
                    w_colour = w_sel_colour;
                    w_gid    = w_sel;
                    if (w_off) begin
                        w_ack = w_sel_oh;
                        if (r_drop != 8'hFF) w_drop = r_drop + 8'd1;
                    end else begin
                        w_plot = 1'b1;
                        w_hold = 4'(PLOT_HOLD);
                    end
                end
            end
            S_PLOT: begin
                w_hold = r_hold - 4'd1;
                if (r_hold <= 4'd1) w_ack  = w_gid_oh;
                else                w_plot = 1'b1;
            end
            S_ACK: begin
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
                if (r_gid != 3'(NREQ-1))
                    w_rr_ptr = (r_gid == 3'(NREQ-1)) ? 3'd0 : r_gid + 3'd1;
`else
                w_rr_ptr = (r_gid == 3'(NREQ-1)) ? 3'd0 : r_gid + 3'd1;
`endif
            end
            default: ;
        endcase
    end

    assign ack        = r_ack;
    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign grant_id   = r_gid;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - self-checking bench for plot_arbiter with a transaction-schedule model
module tb_plot_arbiter;
    localparam int NREQ = 5;
    localparam int PH   = 2;
    localparam int XM   = 160;
    localparam int YM   = 120;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              enable;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_x;
    logic [7*NREQ-1:0] req_y;
    logic [3*NREQ-1:0] req_colour;
    logic [NREQ-1:0]   ack;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic              busy;
    logic [2:0]        grant_id;
    logic [7:0]        drop_count;

    logic [7:0] rx [NREQ];
    logic [6:0] ry [NREQ];
    logic [2:0] rc [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_x[8*g +: 8]      = rx[g];
        assign req_y[7*g +: 7]      = ry[g];
        assign req_colour[3*g +: 3] = rc[g];
    end

    plot_arbiter #(.NREQ(NREQ), .PLOT_HOLD(PH), .X_MAX(XM), .Y_MAX(YM)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .req(req),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .ack(ack),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
        .grant_id(grant_id), .drop_count(drop_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester behaviour: drop req on the edge that samples ack; optionally re-raise one cycle later.
    logic [NREQ-1:0] ack_seen = '0;
    logic [NREQ-1:0] auto_rearm = '0;
    logic [NREQ-1:0] rearm = '0;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i] === 1'b1) begin
                req[i]   = 1'b0;
                rearm[i] = auto_rearm[i];
            end else if (rearm[i] && auto_rearm[i]) begin
                req[i]   = 1'b1;
                rearm[i] = 1'b0;
            end
        end
    endtask

    // Model: each transaction is a schedule of absolute cycle numbers (ARB, plot window, ack).
    int   cyc = 0;
    logic m_valid = 1'b0;
    int   m_busy_to, m_arb_at, m_ack_at, m_pf, m_pt, m_ack_id, m_rr, m_gid, m_drop;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic [NREQ-1:0] e_ack;
    int ack_log_id[$];
    int ack_log_cyc[$];
    int ack_cnt[NREQ];

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
        if (r[NREQ-1]) return NREQ-1;
        for (int k = 0; k < NREQ; k++)
            if (((rr + k) % NREQ) != NREQ-1 && r[(rr + k) % NREQ]) return (rr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
        return -1;
    endfunction

    initial begin : monitor
        int w;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge CLOCK_50);
            ack_seen = ack;
            if (m_valid) begin
                e_ack = '0;
                if (cyc == m_ack_at) e_ack[m_ack_id] = 1'b1;
                check("plot", plot, (cyc >= m_pf && cyc <= m_pt));
                check("ack", ack, e_ack);
                check("busy", busy, (cyc <= m_busy_to));
                check("x", x, m_x);
                check("y", y, m_y);
                check("colour", colour, m_c);
                check("grant_id", grant_id, m_gid);
                check("drop_count", drop_count, m_drop);
                check("ack_onehot", $onehot0(ack), 1);
                for (int i = 0; i < NREQ; i++)
                    if (ack[i] === 1'b1) begin
                        ack_log_id.push_back(i);
                        ack_log_cyc.push_back(cyc);
                        ack_cnt[i]++;
                    end
            end
            if (reset) begin
                m_valid = 1'b1; m_busy_to = cyc; m_arb_at = -1; m_ack_at = -1;
                m_pf = 0; m_pt = -1; m_ack_id = 0; m_rr = 0; m_gid = 0; m_drop = 0;
                m_x = '0; m_y = '0; m_c = '0;
            end else if (m_valid) begin
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
                if (cyc == m_ack_at && m_ack_id != NREQ-1) m_rr = (m_ack_id + 1) % NREQ;
`else
                if (cyc == m_ack_at) m_rr = (m_ack_id + 1) % NREQ;
`endif
                if (cyc == m_arb_at) begin
                    w = pick(req, m_rr);
                    if (w < 0) m_busy_to = cyc;
                    else begin
                        m_x = rx[w]; m_y = ry[w]; m_c = rc[w]; m_gid = w; m_ack_id = w;
                        if (rx[w] >= XM || ry[w] >= YM) begin
                            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                            m_ack_at = cyc + 1; m_busy_to = cyc + 1;
                        end else begin
                            m_pf = cyc + 1; m_pt = cyc + PH;
                            m_ack_at = cyc + PH + 1; m_busy_to = m_ack_at;
                        end
                    end
                end else if (cyc > m_busy_to && enable && req != '0) begin
                    m_arb_at = cyc + 1; m_busy_to = cyc + 1;
                end
            end
            cyc++;
        end
    end

    task automatic reset_pulse();
        reset = 1'b1; req = '0; rearm = '0; auto_rearm = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while ((busy !== 1'b0 || req != '0) && n < maxc) begin
            tick();
            n++;
        end
        check(name, (busy === 1'b0 && req == '0), 1);
    endtask

    int exp_fair[6] = '{0, 1, 2, 3, 4, 0};
    int exp_pri[3];

    initial begin : stim
        int start, base, b1, n;
        reset = 1'b1; enable = 1'b0; req = '0;
        for (int i = 0; i < NREQ; i++) begin rx[i] = '0; ry[i] = '0; rc[i] = '0; end
        repeat (3) tick();
        reset = 1'b0; enable = 1'b1;

        repeat (20) tick();
        check("idle_plot", plot, 0);
        check("idle_busy", busy, 0);
        check("idle_ack", ack, 0);
        check("idle_x", x, 0);
        check("idle_drop", drop_count, 0);

        rx[0] = 8'd10; ry[0] = 7'd20; rc[0] = 3'd1; req[0] = 1'b1;
        tick();
        check("single_arb_busy", busy, 1);
        check("single_arb_plot", plot, 0);
        tick();
        check("single_plot_c2", plot, 1);
        check("single_x", x, 10);
        check("single_y", y, 20);
        check("single_colour", colour, 1);
        tick();
        check("single_plot_c3", plot, 1);
        tick();
        check("single_ack_c4", ack, 5'b00001);
        check("single_plot_c4", plot, 0);
        check("single_gid", grant_id, 0);
        tick();
        check("single_idle_c5", busy, 0);

        rx[3] = 8'd1; ry[3] = 7'd1; req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        check("viol_arb_busy", busy, 1);
        tick();
        check("viol_idle_busy", busy, 0);
        check("viol_no_ack", ack, 0);

        reset_pulse();
        for (int i = 0; i < NREQ; i++) begin
            rx[i] = 8'(20 + i); ry[i] = 7'(30 + i); rc[i] = 3'(i + 1);
        end
        start = ack_log_id.size();
        auto_rearm = '1; req = '1;
        repeat (32) tick();
        auto_rearm = '0;
        drain("fair_drain", 100);
        n = ack_log_id.size() - start;
        check("fair_count", (n >= 6), 1);
        if (n >= 6)
            for (int k = 0; k < 6; k++) begin
                check($sformatf("fair_order_%0d", k), ack_log_id[start + k], exp_fair[k]);
                if (k > 0)
                    check($sformatf("fair_gap_%0d", k), ack_log_cyc[start + k] - ack_log_cyc[start + k - 1], PH + 3);
            end

        reset_pulse();
        rx[2] = 8'd200; ry[2] = 7'd5; rc[2] = 3'd7;
        base = ack_cnt[2];
        req[2] = 1'b1;
        tick();
        tick();
        check("drop_ack_c2", ack, 5'b00100);
        check("drop_plot", plot, 0);
        check("drop_cnt_1", drop_count, 1);
        check("drop_x_latched", x, 200);
        auto_rearm[2] = 1'b1;
        n = 0;
        while (ack_cnt[2] - base < 300 && n < 2000) begin tick(); n++; end
        check("drop_300_done", (ack_cnt[2] - base >= 300), 1);
        auto_rearm = '0;
        drain("drop_drain", 50);
        check("drop_saturated", drop_count, 255);

        reset_pulse();
        rx[0] = 8'd5; ry[0] = 7'd6; rc[0] = 3'd2;
        rx[1] = 8'd7; ry[1] = 7'd8; rc[1] = 3'd3;
        req = 5'b00011;
        tick();
        tick();
        enable = 1'b0;
        b1 = ack_cnt[1];
        tick();
        tick();
        check("en_ack_completes", ack, 5'b00001);
        repeat (10) tick();
        check("en_stays_idle", busy, 0);
        check("en_no_new_grant", ack_cnt[1] - b1, 0);
        enable = 1'b1;
        drain("en_drain", 50);
        check("en_last_grant", ack_log_id[ack_log_id.size() - 1], 1);

        rx[2] = 8'd3; ry[2] = 7'd4; rc[2] = 3'd5;
        req = 5'b00100;
        tick();
        tick();
        check("rst_in_plot", plot, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_plot0", plot, 0);
        check("rst_ack0", ack, 0);
        check("rst_busy0", busy, 0);
        check("rst_x0", x, 0);
        drain("rst_drain", 50);

        reset_pulse();
`ifdef PLOT_ARB_TIMER_PRIORITY_EN
        exp_pri = '{4, 0, 1};
`else
        exp_pri = '{0, 1, 4};
`endif
        rx[4] = 8'd100; ry[4] = 7'd2; rc[4] = 3'd6;
        start = ack_log_id.size();
        req = 5'b10011;
        drain("pri_drain", 100);
        n = ack_log_id.size() - start;
        check("pri_count", n, 3);
        if (n >= 3)
            for (int k = 0; k < 3; k++)
                check($sformatf("pri_order_%0d", k), ack_log_id[start + k], exp_pri[k]);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
